// File: rtl/if_pkg.sv
// Shared types for the instruction-fetch stage: PC/instruction widths,
// queue entry layout and the fetch FSM encoding.
package if_pkg;

    localparam int ADDR_W  = 6;
    localparam int INSTR_W = 16;

    typedef logic [ADDR_W-1:0]  pc_t;
    typedef logic [INSTR_W-1:0] instr_t;

    typedef struct packed {
        instr_t instr;
        pc_t    pc;
    } fetch_entry_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/if_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory read port plus the decode handshake.
// The fetch stage is the master; memory and decode together form the slave side.
interface if_fetch_if;
    import if_pkg::*;

    logic   imem_ren;
    pc_t    imem_raddr;
    instr_t imem_rdata;
    logic   if_valid;
    logic   if_ready;
    instr_t if_instr;
    pc_t    if_pc;

    modport master (
        output imem_ren, imem_raddr, if_valid, if_instr, if_pc,
        input  imem_rdata, if_ready
    );

    modport slave (
        input  imem_ren, imem_raddr, if_valid, if_instr, if_pc,
        output imem_rdata, if_ready
    );

endinterface

// File: rtl/if_fetch_skid_q.sv
// Two-entry FIFO of fetched words. The head always sits in ent0 so the
// decoder sees a registered instruction/PC with no output mux.
module fetch_skid_q
    import if_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    output logic [1:0]   occ,
    output fetch_entry_t head
);

    fetch_entry_t ent0_q, ent0_d;
    fetch_entry_t ent1_q, ent1_d;
    logic [1:0]   occ_q, occ_d;
    logic         pop_eff;

    always_comb begin
        ent0_d  = ent0_q;
        ent1_d  = ent1_q;
        occ_d   = occ_q;
        pop_eff = pop && (occ_q != 2'd0);
        if (clear) begin
            occ_d = 2'd0;
        end else begin
            case ({push, pop_eff})
                2'b10: begin
                    if (occ_q == 2'd0) begin
                        ent0_d = push_entry;
                        occ_d  = 2'd1;
                    end else if (occ_q == 2'd1) begin
                        ent1_d = push_entry;
                        occ_d  = 2'd2;
                    end
                end
                2'b01: begin
                    ent0_d = ent1_q;
                    occ_d  = occ_q - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged; shift only when the tail holds a word.
                    if (occ_q == 2'd1) begin
                        ent0_d = push_entry;
                    end else begin
                        ent0_d = ent1_q;
                        ent1_d = push_entry;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ent0_q <= '0;
            ent1_q <= '0;
            occ_q  <= 2'd0;
        end else begin
            ent0_q <= ent0_d;
            ent1_q <= ent1_d;
            occ_q  <= occ_d;
        end
    end

    assign occ  = occ_q;
    assign head = ent0_q;

    no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop_eff && !clear && (occ_q == 2'd2)));

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: issues PC-sequenced reads, absorbs the 1-cycle
// memory latency and hands words to decode through a 2-entry skid queue.
//
//   state | meaning
//   ------+-----------------------------------------------
//   IDLE  | no new reads issued; queued/in-flight words drain
//   RUN   | reads issued whenever queue credit allows
module if_fetch
#(
    parameter if_pkg::pc_t RESET_PC = '0
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              redirect_valid,
    input  if_pkg::pc_t       redirect_pc,
    if_fetch_if.master        bus
);
    import if_pkg::*;

    localparam logic [0:0] S_IDLE = IDLE;
    localparam logic [0:0] S_RUN  = RUN;

    logic [0:0]   state_q, state_d;
    pc_t          pc_q, pc_d;
    logic         inflight_q, inflight_d;
    pc_t          inflight_pc_q, inflight_pc_d;

    logic [1:0]   occ;
    fetch_entry_t head;
    fetch_entry_t push_entry;
    logic         pop, push, issue;
    logic [2:0]   credit;
    pc_t          issue_addr;

    always_comb begin
        pop        = (occ != 2'd0) && bus.if_ready;
        // Words already owed to the queue (stored + in flight) after this cycle's pop.
        credit     = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};
        issue      = (state_q == S_RUN) && !rst && (credit < 3'd2);
        issue_addr = redirect_valid ? redirect_pc : pc_q;
        push       = inflight_q && !redirect_valid;
        push_entry = '{instr: bus.imem_rdata, pc: inflight_pc_q};

        state_d = state_q;
        case (state_q)
            S_IDLE:  if (en)  state_d = S_RUN;
            S_RUN:   if (!en) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (issue) begin
            pc_d = issue_addr + 1'b1;
        end else if (redirect_valid) begin
            pc_d = redirect_pc;
        end else begin
            pc_d = pc_q;
        end

        inflight_d    = issue;
        inflight_pc_d = issue ? issue_addr : inflight_pc_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    fetch_skid_q u_skid_q (
        .clk        (clk),
        .rst        (rst),
        .clear      (redirect_valid),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop && !redirect_valid),
        .occ        (occ),
        .head       (head)
    );

    assign bus.imem_ren   = issue;
    assign bus.imem_raddr = issue ? issue_addr : pc_q;
    assign bus.if_valid   = (occ != 2'd0);
    assign bus.if_instr   = head.instr;
    assign bus.if_pc      = head.pc;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: two instances (RESET_PC 0 and 0x3E) each fed by
// a 1-cycle-latency memory model returning 0xA000 + address.
module tb_if_fetch;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       ready;
    logic       redirect_valid;
    logic [5:0] redirect_pc;

    int checks = 0;
    int errors = 0;

    if_fetch_if ifc ();
    if_fetch_if ifc_w ();

    assign ifc.if_ready   = ready;
    assign ifc_w.if_ready = ready;

    if_fetch #(.RESET_PC(6'h00)) dut (
        .clk            (clk),
        .rst            (rst),
        .en             (en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .bus            (ifc.master)
    );

    if_fetch #(.RESET_PC(6'h3E)) dut_w (
        .clk            (clk),
        .rst            (rst),
        .en             (en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .bus            (ifc_w.master)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ifc.imem_ren)   ifc.imem_rdata   <= 16'hA000 + {10'd0, ifc.imem_raddr};
        if (ifc_w.imem_ren) ifc_w.imem_rdata <= 16'hA000 + {10'd0, ifc_w.imem_raddr};
    end

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 6'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (ifc.imem_ren !== 1'b0) begin errors++; $display("FAIL reset_ren: got %b want 0", ifc.imem_ren); end
        checks++; if (ifc.if_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", ifc.if_valid); end
        checks++; if (ifc.if_instr !== 16'h0000) begin errors++; $display("FAIL reset_instr: got %h want 0000", ifc.if_instr); end
        checks++; if (ifc.if_pc !== 6'h00) begin errors++; $display("FAIL reset_pc: got %h want 00", ifc.if_pc); end
    endtask

    task automatic test_stream_backpressure();
        int exp;
        do_reset();
        en = 1'b1; ready = 1'b1;
        @(negedge clk); #1;
        checks++; if (ifc.imem_ren !== 1'b1 || ifc.imem_raddr !== 6'h00) begin errors++; $display("FAIL stream_first_issue: got ren=%b addr=%h want ren=1 addr=00", ifc.imem_ren, ifc.imem_raddr); end
        @(negedge clk); #1;
        checks++; if (ifc.if_valid !== 1'b0) begin errors++; $display("FAIL stream_valid_c1: got %b want 0", ifc.if_valid); end
        checks++; if (ifc.imem_ren !== 1'b1 || ifc.imem_raddr !== 6'h01) begin errors++; $display("FAIL stream_second_issue: got ren=%b addr=%h want ren=1 addr=01", ifc.imem_ren, ifc.imem_raddr); end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); #1;
            checks++;
            if (ifc.if_valid !== 1'b1 || ifc.if_instr !== 16'hA000 + 16'(k) || ifc.if_pc !== 6'(k)) begin
                errors++; $display("FAIL stream_word%0d: got v=%b i=%h pc=%h want v=1 i=%h pc=%h", k, ifc.if_valid, ifc.if_instr, ifc.if_pc, 16'hA000 + 16'(k), 6'(k));
            end
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); ready = 1'b0; #1;
            checks++;
            if (ifc.imem_ren !== 1'b0 || ifc.if_valid !== 1'b1 || ifc.if_instr !== 16'hA005 || ifc.if_pc !== 6'h05) begin
                errors++; $display("FAIL bp_hold%0d: got ren=%b v=%b i=%h pc=%h want ren=0 v=1 i=a005 pc=05", k, ifc.imem_ren, ifc.if_valid, ifc.if_instr, ifc.if_pc);
            end
        end
        exp = 5;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk); ready = 1'b1; #1;
            if (k == 0) begin
                checks++; if (ifc.imem_ren !== 1'b1 || ifc.imem_raddr !== 6'h07) begin errors++; $display("FAIL bp_resume_issue: got ren=%b addr=%h want ren=1 addr=07", ifc.imem_ren, ifc.imem_raddr); end
            end
            checks++;
            if (ifc.if_valid !== 1'b1 || ifc.if_instr !== 16'hA000 + 16'(exp) || ifc.if_pc !== 6'(exp)) begin
                errors++; $display("FAIL bp_resume_word%0d: got v=%b i=%h pc=%h want v=1 i=%h pc=%h", exp, ifc.if_valid, ifc.if_instr, ifc.if_pc, 16'hA000 + 16'(exp), 6'(exp));
            end
            exp++;
        end
    endtask

    task automatic test_redirect();
        do_reset();
        en = 1'b1; ready = 1'b1;
        repeat (6) @(negedge clk);
        @(negedge clk); redirect_valid = 1'b1; redirect_pc = 6'h20; #1;
        checks++; if (ifc.if_pc !== 6'h04) begin errors++; $display("FAIL redir_pre_head: got %h want 04", ifc.if_pc); end
        checks++; if (ifc.imem_ren !== 1'b1 || ifc.imem_raddr !== 6'h20) begin errors++; $display("FAIL redir_issue: got ren=%b addr=%h want ren=1 addr=20", ifc.imem_ren, ifc.imem_raddr); end
        @(negedge clk); redirect_valid = 1'b0; #1;
        checks++; if (ifc.if_valid !== 1'b0) begin errors++; $display("FAIL redir_flush: got v=%b want 0", ifc.if_valid); end
        checks++; if (ifc.imem_raddr !== 6'h21) begin errors++; $display("FAIL redir_next_addr: got %h want 21", ifc.imem_raddr); end
        @(negedge clk); #1;
        checks++; if (ifc.if_valid !== 1'b1 || ifc.if_pc !== 6'h20 || ifc.if_instr !== 16'hA020) begin errors++; $display("FAIL redir_target: got v=%b pc=%h i=%h want v=1 pc=20 i=a020", ifc.if_valid, ifc.if_pc, ifc.if_instr); end
        @(negedge clk); #1;
        checks++; if (ifc.if_valid !== 1'b1 || ifc.if_pc !== 6'h21 || ifc.if_instr !== 16'hA021) begin errors++; $display("FAIL redir_target_plus1: got v=%b pc=%h i=%h want v=1 pc=21 i=a021", ifc.if_valid, ifc.if_pc, ifc.if_instr); end
    endtask

    task automatic test_wrap();
        logic [5:0] exp_pc [4];
        exp_pc[0] = 6'h3E; exp_pc[1] = 6'h3F; exp_pc[2] = 6'h00; exp_pc[3] = 6'h01;
        do_reset();
        en = 1'b1; ready = 1'b1;
        @(negedge clk); #1;
        checks++; if (ifc_w.imem_ren !== 1'b1 || ifc_w.imem_raddr !== 6'h3E) begin errors++; $display("FAIL wrap_first_issue: got ren=%b addr=%h want ren=1 addr=3e", ifc_w.imem_ren, ifc_w.imem_raddr); end
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            checks++;
            if (ifc_w.if_valid !== 1'b1 || ifc_w.if_pc !== exp_pc[k] || ifc_w.if_instr !== 16'hA000 + {10'd0, exp_pc[k]}) begin
                errors++; $display("FAIL wrap_word%0d: got v=%b pc=%h i=%h want v=1 pc=%h i=%h", k, ifc_w.if_valid, ifc_w.if_pc, ifc_w.if_instr, exp_pc[k], 16'hA000 + {10'd0, exp_pc[k]});
            end
        end
    endtask

    task automatic test_enable_toggle();
        do_reset();
        en = 1'b1; ready = 1'b1;
        repeat (4) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); en = 1'b0; ready = 1'b0; #1;
            checks++;
            if (ifc.imem_ren !== 1'b0 || ifc.if_valid !== 1'b1 || ifc.if_pc !== 6'h02) begin
                errors++; $display("FAIL en_off%0d: got ren=%b v=%b pc=%h want ren=0 v=1 pc=02", k, ifc.imem_ren, ifc.if_valid, ifc.if_pc);
            end
        end
        for (int k = 2; k < 4; k++) begin
            @(negedge clk); ready = 1'b1; #1;
            checks++;
            if (ifc.imem_ren !== 1'b0 || ifc.if_valid !== 1'b1 || ifc.if_pc !== 6'(k) || ifc.if_instr !== 16'hA000 + 16'(k)) begin
                errors++; $display("FAIL en_drain%0d: got ren=%b v=%b pc=%h i=%h want ren=0 v=1 pc=%h i=%h", k, ifc.imem_ren, ifc.if_valid, ifc.if_pc, ifc.if_instr, 6'(k), 16'hA000 + 16'(k));
            end
        end
        @(negedge clk); en = 1'b1; #1;
        checks++; if (ifc.if_valid !== 1'b0 || ifc.imem_ren !== 1'b0) begin errors++; $display("FAIL en_drained: got v=%b ren=%b want v=0 ren=0", ifc.if_valid, ifc.imem_ren); end
        @(negedge clk); #1;
        checks++; if (ifc.imem_ren !== 1'b1 || ifc.imem_raddr !== 6'h04) begin errors++; $display("FAIL en_restart: got ren=%b addr=%h want ren=1 addr=04", ifc.imem_ren, ifc.imem_raddr); end
        @(negedge clk);
        @(negedge clk); #1;
        checks++; if (ifc.if_valid !== 1'b1 || ifc.if_pc !== 6'h04 || ifc.if_instr !== 16'hA004) begin errors++; $display("FAIL en_restart_word: got v=%b pc=%h i=%h want v=1 pc=04 i=a004", ifc.if_valid, ifc.if_pc, ifc.if_instr); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        en = 1'b1; ready = 1'b1;
        repeat (3) @(negedge clk);
        @(negedge clk); ready = 1'b0; rst = 1'b1; #1;
        checks++; if (ifc.imem_ren !== 1'b0) begin errors++; $display("FAIL rst_gate_ren: got %b want 0", ifc.imem_ren); end
        @(negedge clk); rst = 1'b0; ready = 1'b1; #1;
        checks++; if (ifc.if_valid !== 1'b0 || ifc.imem_ren !== 1'b0) begin errors++; $display("FAIL rst_mid_clear: got v=%b ren=%b want v=0 ren=0", ifc.if_valid, ifc.imem_ren); end
        checks++; if (ifc.if_instr !== 16'h0000 || ifc.if_pc !== 6'h00) begin errors++; $display("FAIL rst_mid_head: got i=%h pc=%h want i=0000 pc=00", ifc.if_instr, ifc.if_pc); end
        @(negedge clk); #1;
        checks++; if (ifc.imem_ren !== 1'b1 || ifc.imem_raddr !== 6'h00) begin errors++; $display("FAIL rst_restart: got ren=%b addr=%h want ren=1 addr=00", ifc.imem_ren, ifc.imem_raddr); end
        @(negedge clk); #1;
        checks++; if (ifc.if_valid !== 1'b0) begin errors++; $display("FAIL rst_restart_gap: got v=%b want 0", ifc.if_valid); end
        @(negedge clk); #1;
        checks++; if (ifc.if_valid !== 1'b1 || ifc.if_pc !== 6'h00 || ifc.if_instr !== 16'hA000) begin errors++; $display("FAIL rst_restart_word: got v=%b pc=%h i=%h want v=1 pc=00 i=a000", ifc.if_valid, ifc.if_pc, ifc.if_instr); end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 6'h00;
        test_reset();
        test_stream_backpressure();
        test_redirect();
        test_wrap();
        test_enable_toggle();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
